// File: rtl/ram_writer_pkg.sv
// Shared definitions for the RAM word writer: FSM encoding and nibble-slot geometry.
package ram_writer_pkg;

    localparam int NIBBLES = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector for a level button; history resets high so a
// button already held when reset releases does not produce a spurious edge.
module edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic level_i,
    output logic rise_o
);

    logic prev_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) prev_q <= 1'b1;
        else         prev_q <= level_i;
    end

    assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/ram_word_writer.sv
// Assembles a word nibble-by-nibble from switches and writes it to memory with an ack timeout.
// Optional RAM_WRITER_AUTOINC_EN: write address comes from an internal counter instead of addr_i.
module ram_word_writer
    import ram_writer_pkg::*;
#(
    parameter int D      = 3,
    parameter int W      = 32,
    parameter int ACK_TO = 255
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [D-1:0]     addr_i,
    input  logic [3:0]       nibble_i,
    input  logic             load_i,
    input  logic             commit_i,
    input  logic             wr_ack_i,
    output logic             wr_req_o,
    output logic [D-1:0]     wr_addr_o,
    output logic [W-1:0]     wr_data_o,
    output logic [W-1:0]     word_o,
    output logic [IDX_W-1:0] nib_idx_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam int CNT_W = $clog2(ACK_TO + 1);

    state_t            state_q, state_d;
    logic              load_edge, commit_edge, timeout;
    logic [W-1:0]      word_q, data_q;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [D-1:0]      addr_q, commit_addr;
    logic              err_q;

    edge_detect u_load_edge (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .level_i (load_i),
        .rise_o  (load_edge)
    );

    edge_detect u_commit_edge (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .level_i (commit_i),
        .rise_o  (commit_edge)
    );

`ifdef RAM_WRITER_AUTOINC_EN
    logic [D-1:0] auto_addr_q;
    logic         unused_addr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                 auto_addr_q <= '0;
        else if (state_q == ST_DONE) auto_addr_q <= auto_addr_q + D'(1);
    end

    assign commit_addr = auto_addr_q;
    assign unused_addr = ^addr_i;
`else
    assign commit_addr = addr_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        unique case (state_q)
            ST_IDLE:  if (commit_edge) state_d = ST_WRITE;
            ST_WRITE: begin
                if (wr_ack_i) begin
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(ACK_TO - 1)) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // Commit wins over a coincident load; that nibble is dropped.
                    if (commit_edge) begin
                        data_q <= word_q;
                        addr_q <= commit_addr;
                        cnt_q  <= '0;
                        err_q  <= 1'b0;
                    end else if (load_edge) begin
                        word_q[{idx_q, 2'b00} +: 4] <= nibble_i;
                        idx_q <= (idx_q == IDX_W'(NIBBLES - 1)) ? '0 : idx_q + IDX_W'(1);
                    end
                end
                ST_WRITE: begin
                    if (timeout)        err_q <= 1'b1;
                    else if (!wr_ack_i) cnt_q <= cnt_q + CNT_W'(1);
                end
                ST_DONE: begin
                    word_q <= '0;
                    idx_q  <= '0;
                end
                default: ;
            endcase
        end
    end

    // Request is a pure state decode so an async reset drops it immediately.
    assign wr_req_o  = (state_q == ST_WRITE);
    assign busy_o    = (state_q == ST_WRITE);
    assign done_o    = (state_q == ST_DONE);
    assign wr_addr_o = addr_q;
    assign wr_data_o = data_q;
    assign word_o    = word_q;
    assign nib_idx_o = idx_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_ram_word_writer.sv
// Directed bench for ram_word_writer; write transactions go through a scoreboard queue.
// Runs the autoinc address sequence when RAM_WRITER_AUTOINC_EN is defined.
module tb_ram_word_writer;

    localparam int D      = 3;
    localparam int W      = 32;
    localparam int ACK_TO = 4;

    typedef struct packed {
        logic [D-1:0] addr;
        logic [W-1:0] data;
    } wr_t;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic [D-1:0] addr_i;
    logic [3:0]   nibble_i;
    logic         load_i, commit_i, wr_ack_i;
    logic         wr_req_o, busy_o, done_o, err_o;
    logic [D-1:0] wr_addr_o;
    logic [W-1:0] wr_data_o, word_o;
    logic [2:0]   nib_idx_o;

    int n_checks = 0;
    int n_errors = 0;

    wr_t          exp_q[$];
    wr_t          cur_exp = '0;
    logic         req_prev = 1'b0;
    logic [W-1:0] model_word = '0;
    logic [2:0]   model_idx = '0;
    logic [D-1:0] model_auto = '0;

    always #5 clk = ~clk;

    ram_word_writer #(.D(D), .W(W), .ACK_TO(ACK_TO)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .addr_i    (addr_i),
        .nibble_i  (nibble_i),
        .load_i    (load_i),
        .commit_i  (commit_i),
        .wr_ack_i  (wr_ack_i),
        .wr_req_o  (wr_req_o),
        .wr_addr_o (wr_addr_o),
        .wr_data_o (wr_data_o),
        .word_o    (word_o),
        .nib_idx_o (nib_idx_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp();
        wr_t e;
`ifdef RAM_WRITER_AUTOINC_EN
        e.addr = model_auto;
`else
        e.addr = addr_i;
`endif
        e.data = model_word;
        exp_q.push_back(e);
    endtask

    task automatic load_nib(input logic [3:0] n);
        nibble_i = n;
        load_i   = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
        @(negedge clk);
        model_word = (model_word & ~(W'(4'hF) << (4 * model_idx))) | (W'(n) << (4 * model_idx));
        model_idx  = model_idx + 3'd1;
    endtask

    // Drives a commit, optionally acks on the Nth request cycle (0 = never) and
    // optionally bounces load during WRITE; counts request-high and done cycles.
    task automatic run_write(input int ack_after, input bit poke_load,
                             output int req_cycles, output int done_cycles);
        req_cycles  = 0;
        done_cycles = 0;
        push_exp();
        commit_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            commit_i = 1'b0;
            wr_ack_i = 1'b0;
            nibble_i = 4'hF;
            load_i   = poke_load && (i == 1);
            if (done_o) done_cycles++;
            if (wr_req_o) begin
                req_cycles++;
                if (ack_after > 0 && req_cycles == ack_after) wr_ack_i = 1'b1;
            end
        end
        load_i = 1'b0;
        if (ack_after > 0) begin
            model_word = '0;
            model_idx  = '0;
            model_auto = model_auto + D'(1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},  wr_req_o,  0);
        check({tag, "_addr"}, wr_addr_o, 0);
        check({tag, "_data"}, wr_data_o, 0);
        check({tag, "_word"}, word_o,    0);
        check({tag, "_idx"},  nib_idx_o, 0);
        check({tag, "_busy"}, busy_o,    0);
        check({tag, "_done"}, done_o,    0);
        check({tag, "_err"},  err_o,     0);
    endtask

    // Scoreboard: pop on each request rise; address/data must hold while requested.
    initial begin
        forever begin
            @(negedge clk);
            if (wr_req_o && !req_prev) begin
                check("sb_entry_present", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) cur_exp = exp_q.pop_front();
            end
            if (wr_req_o) begin
                check("sb_wr_addr", wr_addr_o, cur_exp.addr);
                check("sb_wr_data", wr_data_o, cur_exp.data);
            end
            req_prev = wr_req_o;
        end
    end

    initial begin
        int rq, dn;
        rst_ni   = 1'b0;
        addr_i   = '0;
        nibble_i = '0;
        load_i   = 1'b0;
        commit_i = 1'b0;
        wr_ack_i = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_ni = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_rst");

        // Eight loads fill every slot and wrap the index
        for (int i = 1; i <= 8; i++) begin
            load_nib(4'(i));
            check("load_idx", nib_idx_o, model_idx);
        end
        check("load8_word", word_o, 32'h8765_4321);
        check("load8_idx",  nib_idx_o, 0);

        // Acknowledged write: addr 5, 0xDEADBEEF, ack on third request cycle
        load_nib(4'hF); load_nib(4'hE); load_nib(4'hE); load_nib(4'hB);
        load_nib(4'hD); load_nib(4'hA); load_nib(4'hE); load_nib(4'hD);
        check("beef_word", word_o, 32'hDEAD_BEEF);
        addr_i = 3'd5;
        run_write(3, 1'b0, rq, dn);
        check("ack_req_cycles", rq, 3);
        check("ack_done_pulses", dn, 1);
        check("ack_word_cleared", word_o, 0);
        check("ack_idx_cleared", nib_idx_o, 0);
        check("ack_busy", busy_o, 0);
        check("ack_err", err_o, 0);

        // Coincident load+commit, then timeout with a load bounced during WRITE
        load_nib(4'hA);
        load_nib(4'hB);
        addr_i   = 3'd2;
        nibble_i = 4'hC;
        load_i   = 1'b1;
        run_write(0, 1'b1, rq, dn);
        check("to_req_cycles", rq, ACK_TO);
        check("to_done_pulses", dn, 0);
        check("to_err_set", err_o, 1);
        check("to_word_kept", word_o, 32'h0000_00BA);
        check("to_idx_kept", nib_idx_o, 2);
        check("to_busy", busy_o, 0);

        // Next commit clears the sticky error
        addr_i = 3'd6;
        run_write(2, 1'b0, rq, dn);
        check("clr_req_cycles", rq, 2);
        check("clr_done_pulses", dn, 1);
        check("clr_err", err_o, 0);
        check("clr_word", word_o, 0);

        // Reset during WRITE drops the request at once, no done
        load_nib(4'h3);
        addr_i = 3'd1;
        push_exp();
        commit_i = 1'b1;
        @(negedge clk);
        commit_i = 1'b0;
        check("mid_req_high", wr_req_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        check("mid_rst_req", wr_req_o, 0);
        check("mid_rst_done", done_o, 0);
        check("mid_rst_busy", busy_o, 0);
        model_word = '0;
        model_idx  = '0;
        model_auto = '0;

        // Load held high through reset release produces no load
        @(negedge clk);
        nibble_i = 4'h9;
        load_i   = 1'b1;
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("held_load");
        load_i = 1'b0;
        @(negedge clk);
        load_nib(4'h5);
        check("after_rst_word", word_o, 32'h0000_0005);
        check("after_rst_idx", nib_idx_o, 1);

`ifdef RAM_WRITER_AUTOINC_EN
        // Nine acknowledged writes: scoreboard expects addresses 0..7 then 0
        for (int k = 0; k < 9; k++) begin
            addr_i = 3'd7 - 3'(k);
            load_nib(4'(k + 1));
            run_write(1, 1'b0, rq, dn);
            check("auto_req_cycles", rq, 1);
            check("auto_done_pulses", dn, 1);
        end
        check("auto_wrapped", model_auto, 1);
`endif

        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_word_writer.md
RAM_WORD_WRITER -- requirements
Module: ram_word_writer

Interface
REQ-001 SHALL have parameter D, default 3: address width.
REQ-002 SHALL have parameter W, default 32: data word width; fixed at 8 nibbles.
REQ-003 SHALL have parameter ACK_TO, default 255: maximum cycles to wait for wr_ack_i.
REQ-004 SHALL have port clk_i  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port addr_i  input  D  target address (switches).
REQ-007 SHALL have port nibble_i  input  4  nibble value to load (switches).
REQ-008 SHALL have port load_i  input  1  load button, level; its rising edge loads one nibble.
REQ-009 SHALL have port commit_i  input  1  commit button, level; its rising edge starts a write.
REQ-010 SHALL have port wr_ack_i  input  1  memory acknowledge for the current request.
REQ-011 SHALL have port wr_req_o  output  1  write request to memory.
REQ-012 SHALL have port wr_addr_o  output  D  write address.
REQ-013 SHALL have port wr_data_o  output  W  write data.
REQ-014 SHALL have port word_o  output  W  word currently being assembled, for the display path.
REQ-015 SHALL have port nib_idx_o  output  3  next nibble slot; same encoding as the board byte selector.
REQ-016 SHALL have port busy_o  output  1  high in WRITE.
REQ-017 SHALL have port done_o  output  1  one-cycle pulse on an acknowledged write.
REQ-018 SHALL have port err_o  output  1  sticky ack-timeout flag.

Function
REQ-019 SHALL implement FSM states IDLE, WRITE and DONE; IDLE->WRITE on a commit edge; WRITE->DONE on wr_ack_i; WRITE->IDLE on timeout; DONE->IDLE always.
REQ-020 SHALL, in IDLE on a load edge, write nibble_i into word bits [4*idx+3:4*idx] and increment idx, wrapping 7->0; all other bits are unchanged.
REQ-021 SHALL, on a commit edge in IDLE, register the word and address into wr_data_o and wr_addr_o and assert wr_req_o on the next cycle.
REQ-022 SHALL hold wr_req_o, wr_addr_o and wr_data_o stable until ack or timeout; wr_req_o drops the cycle after wr_ack_i is sampled high.
REQ-023 SHALL ignore wr_ack_i outside WRITE.
REQ-024 SHALL give commit priority when load and commit edges coincide; the nibble is dropped.
REQ-025 SHALL ignore load and commit edges during WRITE and DONE; they are not queued.
REQ-026 SHALL count WRITE cycles; after ACK_TO cycles without ack, deassert wr_req_o, set err_o and return to IDLE; the word is kept.
REQ-027 SHALL, in DONE, pulse done_o, clear word_o to 0 and set idx to 0.
REQ-028 SHALL clear err_o on the next commit edge.
REQ-029 SHALL detect an edge as level high this cycle and low in the previous registered sample; latency from edge to action is 1 cycle.

Reset
REQ-030 SHALL, on reset, go to IDLE with wr_req_o=0, wr_addr_o=0, wr_data_o=0, word_o=0, nib_idx_o=0, busy_o=0, done_o=0, err_o=0 and the timeout counter at 0.
REQ-031 SHALL reset edge-detector history to 1, so a button held through reset release produces no edge.
REQ-032 SHALL, if reset asserts during WRITE, drop wr_req_o immediately with no done_o.

Configuration
REQ-033 SHALL, with RAM_WRITER_AUTOINC_EN defined, take wr_addr_o from an internal counter (reset 0) that increments after each acknowledged write, wraps 2^D-1->0, and ignores addr_i.
REQ-034 SHALL, without RAM_WRITER_AUTOINC_EN, set wr_addr_o to addr_i sampled at the commit edge.

Structure
REQ-035 SHALL place the state encoding, the nibble count (8) and the index width (3) in shared package ram_writer_pkg.
REQ-036 SHALL instantiate sub-module edge_detect (registered rising-edge detector, reset value 1) once for load_i and once for commit_i.

Verification
REQ-037 SHALL test load nibbles 1..8 -> word_o=0x87654321, nib_idx_o=0 after the 8th load.
REQ-038 SHALL test addr_i=5, word 0xDEADBEEF, commit, ack after 3 cycles -> wr_req_o high 3 cycles, wr_addr_o=5, wr_data_o=0xDEADBEEF, one done_o pulse, word_o=0.
REQ-039 SHALL test load and commit in the same cycle -> a write starts with the old word, the nibble is dropped and idx is unchanged.
REQ-040 SHALL test with ACK_TO=4 and no ack -> wr_req_o drops after 4 cycles, err_o=1, word kept; the next commit clears err_o.
REQ-041 SHALL test load_i held high across reset release -> no nibble loaded; reset during WRITE -> wr_req_o=0 the same cycle.
REQ-042 SHALL test, with RAM_WRITER_AUTOINC_EN, 9 acknowledged writes at D=3 -> addresses 0..7 then 0.
